// File: rtl/uart_pkg.sv
// Shared receive-side definitions: FSM state encoding, oversample constants, word-length mask.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        LOAD   = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);

    // wls 00..11 selects 5..8 data bits; returns the matching low-bit mask.
    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        return 8'hFF >> (2'd3 - wls);
    endfunction

endpackage

// File: rtl/uart_receiver_ctrl_if.sv
// Host-side view of the receiver: buffer/status reads and the status bits themselves.
// Latency: n/a (signal bundle only).
// Backpressure: none; rbr_read/lsr_read are one-cycle pulses from the host.
// master = host (issues reads), slave = receiver controller (owns buffer and status).
interface uart_receiver_ctrl_if;
    logic       rbr_read;
    logic       lsr_read;
    logic [7:0] rbr_data;
    logic       data_ready;
    logic       overrun_error;
    logic       parity_error;
    logic       framing_error;
    logic       rx_busy;

    modport master (
        output rbr_read, lsr_read,
        input  rbr_data, data_ready, overrun_error, parity_error, framing_error, rx_busy
    );

    modport slave (
        input  rbr_read, lsr_read,
        output rbr_data, data_ready, overrun_error, parity_error, framing_error, rx_busy
    );
endinterface

// File: rtl/uart_rx_parity_check.sv
// Expected parity bit for the received word, honouring word length, even/odd and stick parity.
// Latency: combinational.
// Backpressure: n/a.
// Ports: data (assembled word), wls (word length), eps (even select), sp (stick) -> expected.
module uart_rx_parity_check
    import uart_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       eps,
    input  logic       sp,
    output logic       expected
);
    logic [7:0] masked;

    always_comb begin
        masked = data & wls_mask(wls);
        if (sp) begin
            // stick parity: the bit is a constant, the complement of eps
            expected = ~eps;
        end else if (eps) begin
            expected = ^masked;
        end else begin
            expected = ~^masked;
        end
    end
endmodule

// File: rtl/uart_receiver_ctrl.sv
// UART receive controller: start detect, mid-bit shift strobes, buffer load and line status.
// Latency: shift strobe is combinational with the tick; data_ready rises 2 cycles after mid-stop sample.
// Backpressure: none; an unread buffer is overwritten and flagged as overrun.
// Ports: pckl/preset; baud_tick, rxd, wls/pen/eps/sp line config; rsr_data/received_parity/
//        frame_error from the shift block; receive_shift_en/error_check to it; host via interface.
module uart_receiver_ctrl
    import uart_pkg::*;
(
    input  logic                       pckl,
    input  logic                       preset,
    input  logic                       baud_tick,
    input  logic                       rxd,
    input  logic [1:0]                 wls,
    input  logic                       pen,
    input  logic                       eps,
    input  logic                       sp,
    input  logic [7:0]                 rsr_data,
    input  logic                       received_parity,
    input  logic                       frame_error,
    output logic                       receive_shift_en,
    output logic                       error_check,
    uart_receiver_ctrl_if.slave        host
);
    rx_state_e  state, state_nxt;
    logic [3:0] tick_cnt, tick_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic       shift;
    logic       load;
    logic       par_exp;
    logic [2:0] last_bit;

    // index of the final data bit: word length minus one
    assign last_bit = {1'b0, wls} + 3'd4;

    always_ff @(posedge pckl or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (baud_tick && !rxd) begin
                    state_nxt = START;
                    tick_nxt  = 4'd0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        // line back high at mid start bit: glitch, not a frame
                        if (rxd) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            tick_nxt  = 4'd0;
                            bit_nxt   = 3'd0;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            DATA, PARITY, STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        // counting restarted at mid start bit, so this lands mid-bit
                        shift    = 1'b1;
                        tick_nxt = 4'd0;
                        if (state == DATA) begin
                            bit_nxt = bit_cnt + 3'd1;
                            if (bit_cnt == last_bit) begin
                                state_nxt = pen ? PARITY : STOP;
                            end
                        end else if (state == PARITY) begin
                            state_nxt = STOP;
                        end else begin
                            state_nxt = LOAD;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign receive_shift_en = shift;
    assign load             = (state == LOAD);
    assign error_check      = load;
    assign host.rx_busy     = (state != IDLE);

    uart_rx_parity_check u_parity (
        .data     (rsr_data),
        .wls      (wls),
        .eps      (eps),
        .sp       (sp),
        .expected (par_exp)
    );

    // Status bits: a set in LOAD beats a clearing read in the same cycle.
    always_ff @(posedge pckl or posedge preset) begin
        if (preset) begin
            host.rbr_data      <= 8'h00;
            host.data_ready    <= 1'b0;
            host.overrun_error <= 1'b0;
            host.parity_error  <= 1'b0;
            host.framing_error <= 1'b0;
        end else begin
            if (load) begin
                host.rbr_data <= rsr_data;
            end
            host.data_ready    <= load | (host.data_ready & ~host.rbr_read);
            host.overrun_error <= (load & host.data_ready & ~host.rbr_read)
                                | (host.overrun_error & ~host.lsr_read);
            host.parity_error  <= (load & pen & (received_parity != par_exp))
                                | (host.parity_error & ~host.lsr_read);
            host.framing_error <= (load & frame_error)
                                | (host.framing_error & ~host.lsr_read);
        end
    end
endmodule
